// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP frame sequencer: header constants,
// sequencer state encoding and the byte lanes of a stored pixel pair.
package bmp_pkg;

    localparam logic [7:0] BMP_MAGIC_0      = 8'h42; // 'B'
    localparam logic [7:0] BMP_MAGIC_1      = 8'h4D; // 'M'
    localparam int         BMP_PIXEL_OFFSET = 54;
    localparam int         BMP_DIB_SIZE     = 40;
    localparam int         BMP_PLANES       = 1;
    localparam int         BMP_BPP          = 24;

    localparam int         BYTES_PER_PAIR   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_HEADER,
        ST_PAYLOAD
    } seq_state_e;

    // Byte lanes of a 48-bit pair word {R1,G1,B1,R0,G0,B0}
    localparam int LANE_B0 = 0;
    localparam int LANE_G0 = 1;
    localparam int LANE_R0 = 2;
    localparam int LANE_B1 = 3;
    localparam int LANE_G1 = 4;
    localparam int LANE_R1 = 5;

    // Byte idx of the payload emission order B0,G0,R0,B1,G1,R1
    function automatic logic [7:0] pair_byte(input logic [47:0] word, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = word[LANE_B0*8 +: 8];
            3'd1:    b = word[LANE_G0*8 +: 8];
            3'd2:    b = word[LANE_R0*8 +: 8];
            3'd3:    b = word[LANE_B1*8 +: 8];
            3'd4:    b = word[LANE_G1*8 +: 8];
            3'd5:    b = word[LANE_R1*8 +: 8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Combinational 54-byte BMP/DIB header lookup for a 24-bpp image.
module bmp_header_rom
    import bmp_pkg::*;
#(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512,
    parameter int IDX_W  = 6
) (
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       hdr_byte
);

    localparam logic [31:0] FILE_SIZE = 32'(BMP_PIXEL_OFFSET + WIDTH * HEIGHT * 3);
    localparam logic [31:0] W32       = 32'(WIDTH);
    localparam logic [31:0] H32       = 32'(HEIGHT);

    // Map header byte index to its value; multi-byte fields are little-endian
    always_comb begin
        hdr_byte = 8'h00;
        case (int'(idx))
            0:       hdr_byte = BMP_MAGIC_0;
            1:       hdr_byte = BMP_MAGIC_1;
            2:       hdr_byte = FILE_SIZE[7:0];
            3:       hdr_byte = FILE_SIZE[15:8];
            4:       hdr_byte = FILE_SIZE[23:16];
            5:       hdr_byte = FILE_SIZE[31:24];
            10:      hdr_byte = 8'(BMP_PIXEL_OFFSET);
            14:      hdr_byte = 8'(BMP_DIB_SIZE);
            18:      hdr_byte = W32[7:0];
            19:      hdr_byte = W32[15:8];
            20:      hdr_byte = W32[23:16];
            21:      hdr_byte = W32[31:24];
            22:      hdr_byte = H32[7:0];
            23:      hdr_byte = H32[15:8];
            24:      hdr_byte = H32[23:16];
            25:      hdr_byte = H32[31:24];
            26:      hdr_byte = 8'(BMP_PLANES);
            28:      hdr_byte = 8'(BMP_BPP);
            default: hdr_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/bmp_frame_sequencer.sv
// Captures a frame of RGB888 pixel pairs into word memory at bottom-up
// row addresses, then streams the BMP header and payload as bytes.
// Output handshake: a byte transfers on a rising HCLK edge where
// out_valid && out_ready; out_byte/out_valid hold while stalled.
module bmp_frame_sequencer
    import bmp_pkg::*;
#(
    parameter int WIDTH     = 512,
    parameter int HEIGHT    = 512,
    parameter int HDR_BYTES = 54,
    parameter int ADDR_W    = $clog2(WIDTH * HEIGHT / 2)
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              frame_start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [47:0]       pix_data,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [47:0]       mem_wdata,
    input  logic [47:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              busy,
    output logic              frame_done
);

    localparam int HALF_W = WIDTH / 2;
    localparam int WORDS  = WIDTH * HEIGHT / 2;
    localparam int COL_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int HI_W   = $clog2(HDR_BYTES + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(HALF_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WORDS - 1);
    localparam logic [HI_W-1:0]   HDR_DONE  = HI_W'(HDR_BYTES);
    localparam logic [2:0]        BYTE_LAST = 3'(BYTES_PER_PAIR);

    seq_state_e        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [HI_W-1:0]   hdr_idx_q, hdr_idx_d;     // next header byte to load
    logic [2:0]        byte_idx_q, byte_idx_d;   // bytes of hold_q already loaded
    logic [47:0]       hold_q, hold_d;
    logic              rd_pend_q, rd_pend_d;     // mem_rdata valid this cycle
    logic              pix_ready_q, pix_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [47:0]       mem_wdata_q, mem_wdata_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_byte_q, out_byte_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic [7:0]        rom_byte;
    logic [ADDR_W-1:0] wr_addr;
    logic              out_hs;

    // Image row 0 lands in the last memory row so the payload reads bottom-up
    assign wr_addr = ADDR_W'((HEIGHT - 1 - int'(row_q)) * HALF_W + int'(col_q));
    assign out_hs  = out_valid_q && out_ready;

    bmp_header_rom #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .IDX_W  (HI_W)
    ) u_header_rom (
        .idx      (hdr_idx_q),
        .hdr_byte (rom_byte)
    );

    // Next-state and next-output computation for capture, header and payload
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        hdr_idx_d    = hdr_idx_q;
        byte_idx_d   = byte_idx_q;
        hold_d       = hold_q;
        rd_pend_d    = mem_re_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        out_valid_d  = out_valid_q;
        out_byte_d   = out_byte_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_CAPTURE;
                    col_d      = '0;
                    row_d      = '0;
                    hdr_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (pix_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = pix_data;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d     = ST_HEADER;
                            out_valid_d = 1'b1;
                            out_byte_d  = rom_byte;
                            hdr_idx_d   = hdr_idx_q + 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                if (out_hs) begin
                    if (hdr_idx_q == HDR_DONE) begin
                        state_d     = ST_PAYLOAD;
                        out_valid_d = 1'b0;
                        mem_re_d    = 1'b1;
                        mem_addr_d  = '0;
                        byte_idx_d  = '0;
                    end else begin
                        out_byte_d = rom_byte;
                        hdr_idx_d  = hdr_idx_q + 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rd_pend_q) begin
                    hold_d      = mem_rdata;
                    out_valid_d = 1'b1;
                    out_byte_d  = pair_byte(mem_rdata, 3'd0);
                    byte_idx_d  = 3'd1;
                end else if (out_hs) begin
                    if (byte_idx_q == BYTE_LAST) begin
                        out_valid_d = 1'b0;
                        if (mem_addr_q == ADDR_LAST) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            mem_re_d   = 1'b1;
                            mem_addr_d = mem_addr_q + 1'b1;
                        end
                    end else begin
                        out_byte_d = pair_byte(hold_q, byte_idx_q);
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pix_ready_d = (state_d == ST_CAPTURE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any frame in progress
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            hdr_idx_q    <= '0;
            byte_idx_q   <= '0;
            hold_q       <= '0;
            rd_pend_q    <= 1'b0;
            pix_ready_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hdr_idx_q    <= hdr_idx_d;
            byte_idx_q   <= byte_idx_d;
            hold_q       <= hold_d;
            rd_pend_q    <= rd_pend_d;
            pix_ready_q  <= pix_ready_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_ready  = pix_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bmp_frame_sequencer.sv
// Bench for bmp_frame_sequencer on a 4x2 image: reset, bottom-up write
// addressing, header contents, payload byte order, backpressure and abort.
module tb_bmp_frame_sequencer;

    localparam int W           = 4;
    localparam int H           = 2;
    localparam int HDR         = 54;
    localparam int AW          = 2;
    localparam int PAIRS_ROW   = W / 2;
    localparam int WORDS       = W * H / 2;
    localparam int FRAME_BYTES = HDR + W * H * 3;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [47:0]   pix_data = '0;
    logic          out_ready = 1'b0;
    logic [47:0]   mem_rdata = '0;
    logic          pix_ready;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [47:0]   mem_wdata;
    logic          out_valid;
    logic [7:0]    out_byte;
    logic          busy;
    logic          frame_done;

    always #5 HCLK = ~HCLK;

    bmp_frame_sequencer #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .HDR_BYTES (HDR),
        .ADDR_W    (AW)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_byte    (out_byte),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // External frame memory: synchronous write, read data one cycle after mem_re
    logic [47:0] mem [WORDS];
    always @(posedge HCLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int cycle = 0;
    always @(posedge HCLK) cycle <= cycle + 1;

    // Scoreboard state
    logic [7:0]       exp_q[$];
    logic [AW+47:0]   exp_wr_q[$];
    int               n_checks = 0;
    int               n_pass = 0;
    int               frame_bytes = 0;
    int               last_hs_cycle = -10;
    int               done_count = 0;
    logic [7:0]       act_stream [FRAME_BYTES];
    logic             done_prev = 1'b0;
    logic             stall_pend = 1'b0;
    logic [7:0]       stall_byte = '0;
    bit               b2b_mode = 1'b0;
    bit               wr_seen = 1'b0;
    int               last_we_cycle = 0;
    bit               ready_random = 1'b0;

    // Reference model: header bytes and the captured picture
    logic [7:0]  hdr_model [HDR];
    logic [47:0] pic [H][PAIRS_ROW];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic void build_header();
        int fsize;
        fsize = 54 + W * H * 3;
        for (int i = 0; i < HDR; i++) hdr_model[i] = 8'h00;
        hdr_model[0] = 8'h42;
        hdr_model[1] = 8'h4D;
        for (int i = 0; i < 4; i++) begin
            hdr_model[2 + i]  = 8'((fsize >> (8 * i)) & 255);
            hdr_model[18 + i] = 8'((W >> (8 * i)) & 255);
            hdr_model[22 + i] = 8'((H >> (8 * i)) & 255);
        end
        hdr_model[10] = 8'd54;
        hdr_model[14] = 8'd40;
        hdr_model[26] = 8'd1;
        hdr_model[28] = 8'd24;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Sink readiness: always ready, or a coin flip every cycle
    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            out_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: output bytes, stall stability, frame_done and memory writes
    initial begin
        logic [AW+47:0] e;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                stall_pend = 1'b0;
                done_prev  = 1'b0;
            end else begin
                if (stall_pend) begin
                    chk("stall_valid_held", 64'(out_valid), 64'd1);
                    chk("stall_byte_held", 64'(out_byte), 64'(stall_byte));
                end
                stall_pend = out_valid && !out_ready;
                stall_byte = out_byte;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL out_byte_unexpected: got 0x%0h, expected no byte", out_byte);
                    end else begin
                        chk($sformatf("out_byte[%0d]", frame_bytes), 64'(out_byte), 64'(exp_q.pop_front()));
                    end
                    if (frame_bytes < FRAME_BYTES) act_stream[frame_bytes] = out_byte;
                    frame_bytes++;
                    last_hs_cycle = cycle;
                end
                if (frame_done) begin
                    chk("frame_done_single_pulse", 64'(done_prev), 64'd0);
                    chk("frame_done_after_last_byte", 64'(cycle - last_hs_cycle), 64'd1);
                    chk("frame_done_byte_count", 64'(frame_bytes), 64'(FRAME_BYTES));
                    chk("frame_done_busy_low", 64'(busy), 64'd0);
                    done_count++;
                    frame_bytes = 0;
                end
                done_prev = frame_done;
                if (mem_we) begin
                    if (exp_wr_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL mem_we_unexpected: got addr %0d data 0x%0h, expected no write", mem_addr, mem_wdata);
                    end else begin
                        e = exp_wr_q.pop_front();
                        chk("mem_addr", 64'(mem_addr), 64'(e[AW+47:48]));
                        chk("mem_wdata", 64'(mem_wdata), 64'(e[47:0]));
                    end
                    if (b2b_mode && wr_seen)
                        chk("mem_we_back_to_back", 64'(cycle - last_we_cycle), 64'd1);
                    wr_seen = 1'b1;
                    last_we_cycle = cycle;
                end
            end
        end
    end

    task automatic start_frame();
        chk("busy_before_frame_start", 64'(busy), 64'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("busy_after_frame_start", 64'(busy), 64'd1);
    endtask

    // Drive one frame of pairs; optionally force pair 0 and insert idle gaps
    task automatic capture(input bit gaps, input bit use_fixed, input logic [47:0] fixed_pair);
        logic [63:0] rnd;
        logic [47:0] d;
        int a;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < PAIRS_ROW; c++) begin
                rnd = {$urandom(), $urandom()};
                d = rnd[47:0];
                if (use_fixed && r == 0 && c == 0) d = fixed_pair;
                if (gaps) begin
                    while ($urandom_range(0, 2) == 0) begin
                        pix_valid = 1'b0;
                        rnd = {$urandom(), $urandom()};
                        pix_data = rnd[47:0];
                        tick();
                    end
                end
                pix_valid = 1'b1;
                pix_data = d;
                chk("pix_ready_in_capture", 64'(pix_ready), 64'd1);
                pic[r][c] = d;
                a = (H - 1 - r) * PAIRS_ROW + c;
                exp_wr_q.push_back({AW'(a), d});
                tick();
            end
        end
        pix_valid = 1'b0;
        chk("header_valid_after_last_pair", 64'(out_valid), 64'd1);
        chk("pix_ready_after_capture", 64'(pix_ready), 64'd0);
        // Expected stream: header, then image rows bottom-up, each pair B0,G0,R0,B1,G1,R1
        for (int i = 0; i < HDR; i++) exp_q.push_back(hdr_model[i]);
        for (int fr = 0; fr < H; fr++)
            for (int c = 0; c < PAIRS_ROW; c++)
                for (int k = 0; k < 6; k++)
                    exp_q.push_back(pic[H - 1 - fr][c][8 * k +: 8]);
    endtask

    task automatic wait_done(input string name);
        int start;
        int guard;
        start = done_count;
        guard = 0;
        while (done_count == start && guard < 4000) begin
            tick();
            guard++;
        end
        if (done_count == start) begin
            n_checks++;
            $display("FAIL %s_timeout: got no frame_done, expected one within 4000 cycles", name);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish before 400000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [63:0] rnd;
        build_header();

        // Reset then idle
        HRESETn = 1'b0;
        repeat (3) tick();
        chk("rst_pix_ready", 64'(pix_ready), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_re", 64'(mem_re), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_byte", 64'(out_byte), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        HRESETn = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1'b1;
            rnd = {$urandom(), $urandom()};
            pix_data = rnd[47:0];
            tick();
            chk("idle_pix_ready_low", 64'(pix_ready), 64'd0);
            chk("idle_busy_low", 64'(busy), 64'd0);
        end
        pix_valid = 1'b0;
        tick();

        // Frame 1: back-to-back pairs, sink always ready, known pair 0
        ready_random = 1'b0;
        b2b_mode = 1'b1;
        wr_seen = 1'b0;
        start_frame();
        capture(1'b0, 1'b1, 48'h060504030201);
        b2b_mode = 1'b0;
        wait_done("frame1");
        chk("hdr_byte0", 64'(act_stream[0]), 64'h42);
        chk("hdr_byte1", 64'(act_stream[1]), 64'h4D);
        chk("hdr_byte2", 64'(act_stream[2]), 64'h4E);
        chk("hdr_byte3", 64'(act_stream[3]), 64'h00);
        chk("hdr_byte18", 64'(act_stream[18]), 64'd4);
        chk("hdr_byte22", 64'(act_stream[22]), 64'd2);
        chk("hdr_byte28", 64'(act_stream[28]), 64'd24);
        for (int k = 0; k < 6; k++)
            chk($sformatf("payload_pos%0d", 12 + k), 64'(act_stream[HDR + 12 + k]), 64'(k + 1));
        tick();
        chk("idle_after_frame1", 64'(busy), 64'd0);

        // Frame 2: gaps on input, random backpressure, frame_start while busy
        ready_random = 1'b1;
        start_frame();
        capture(1'b1, 1'b0, 48'h0);
        repeat (3) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("frame_start_ignored_busy", 64'(busy), 64'd1);
        wait_done("frame2");
        tick();

        // Frame 3: abort with reset in the middle of the payload
        start_frame();
        capture(1'b1, 1'b0, 48'h0);
        guard = 0;
        while (frame_bytes < HDR + 20 && guard < 4000) begin
            tick();
            guard++;
        end
        if (frame_bytes < HDR + 20) begin
            n_checks++;
            $display("FAIL abort_reach_payload: got %0d bytes, expected at least %0d", frame_bytes, HDR + 20);
        end
        HRESETn = 1'b0;
        tick();
        chk("abort_busy_low", 64'(busy), 64'd0);
        chk("abort_out_valid_low", 64'(out_valid), 64'd0);
        chk("abort_mem_re_low", 64'(mem_re), 64'd0);
        exp_q.delete();
        exp_wr_q.delete();
        frame_bytes = 0;
        HRESETn = 1'b1;
        tick();

        // Frame 4: clean frame after abort
        start_frame();
        capture(1'b1, 1'b0, 48'h0);
        wait_done("frame4");
        repeat (2) tick();

        chk("exp_bytes_drained", 64'(exp_q.size()), 64'd0);
        chk("exp_writes_drained", 64'(exp_wr_q.size()), 64'd0);
        chk("frame_done_total", 64'(done_count), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bmp_frame_sequencer.md
# bmp_frame_sequencer

Controller for the output frame path. It accepts the processed RGB888 pixel-pair stream and sequences the pairs into an external frame word memory at bottom-up BMP row addresses. Once a full frame is stored, it replays the 54-byte BMP header and the payload as a byte stream with valid/ready handshaking. It sits between the processing pipeline and the file/host sink, and replaces free-running counting on hsync.

## Interface
Parameters:
- WIDTH, 512, image width in pixels; must be even.
- HEIGHT, 512, image height in rows.
- HDR_BYTES, 54, BMP header length in bytes.
- ADDR_W, $clog2(WIDTH*HEIGHT/2), frame memory word address width (17 at default).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset: HRESETn, asynchronous, active-low; clock HCLK.
- frame_start  in  1  one-cycle pulse; arms capture. Honoured in IDLE only.
- pix_valid  in  1  pixel pair present.
- pix_ready  out  1  pair accepted when pix_valid && pix_ready.
- pix_data  in  48  {R1,G1,B1,R0,G0,B0}, 8 bits each.
- mem_we  out  1  frame memory write strobe.
- mem_re  out  1  frame memory read strobe.
- mem_addr  out  ADDR_W  word address, one word per pair.
- mem_wdata  out  48  write word, byte order {R1,G1,B1,R0,G0,B0}.
- mem_rdata  in  48  read word, valid exactly 1 cycle after mem_re.
- out_valid  out  1  output byte valid.
- out_ready  in  1  sink ready.
- out_byte  out  8  header or payload byte.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last payload byte is accepted.

## Operation
- FSM states: IDLE, CAPTURE, HEADER, PAYLOAD.
- IDLE -> CAPTURE on frame_start. In CAPTURE the column counter col resets to 0 and the row counter row resets to 0.
- CAPTURE:
  - pix_ready = 1.
  - Each accepted pair writes address (HEIGHT-1-row)*(WIDTH/2)+col.
  - col wraps at WIDTH/2-1 and increments row.
  - The pair accepted with row=HEIGHT-1 and col=WIDTH/2-1 moves the FSM to HEADER.
  - pix_ready is 0 in every other state. pix_valid outside CAPTURE is ignored and writes nothing.
- HEADER:
  - Emits bytes 0..HDR_BYTES-1 from sub-module bmp_header_rom: "BM"; file size 54+WIDTH*HEIGHT*3 little-endian at bytes 2..5; 54 at byte 10; 40 at byte 14; WIDTH at bytes 18..21; HEIGHT at bytes 22..25; 1 at byte 26; 24 at byte 28; all other bytes 0.
  - After byte HDR_BYTES-1 is accepted, the FSM moves to PAYLOAD with read address 0.
- PAYLOAD:
  - Words are read at ascending addresses 0..WIDTH*HEIGHT/2-1.
  - Each word is emitted as B0,G0,R0,B1,G1,R1.
  - The next read issues when the sixth byte is accepted.
  - After the last byte of the last word is accepted: frame_done pulse, then IDLE.
- frame_start is ignored while busy.
- Row padding is not generated. WIDTH*3 must be a multiple of 4; this is a documented restriction.

## Timing
- Reset values: pix_ready 0, mem_we 0, mem_re 0, mem_addr 0, mem_wdata 0, out_valid 0, out_byte 0, busy 0, frame_done 0. FSM in IDLE, all counters 0.
- mem_we, mem_addr and mem_wdata are registered: the write appears the cycle after acceptance.
- busy rises the cycle after frame_start.
- The first header byte is valid the cycle after the final pair is accepted.
- out_byte and out_valid are registered and held stable while out_valid && !out_ready.
- Payload fetch:
  - The transition into PAYLOAD asserts mem_re for address 0.
  - Byte B0 becomes valid 2 cycles after mem_re: data returns 1 cycle after mem_re and is registered into the holding register.
  - Each word boundary therefore costs 2 bubble cycles with out_valid=0.
  - No read is issued while the holding register is occupied.
- frame_done is asserted in the cycle after the final handshake. busy falls in the same cycle.
- Reset mid-operation aborts immediately. A partial frame is abandoned and memory contents are don't-care.

## Structure
- Shared package bmp_pkg holds:
  - the BMP header constants (magic, offset 54, DIB size 40, bpp 24);
  - the FSM state enum;
  - the pixel-pair byte lane positions.
- Sub-module bmp_header_rom: combinational header byte index (0..53) -> byte, parameterised by WIDTH and HEIGHT.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2 unless stated.
1. Reset then idle: HRESETn low for 3 cycles -> all outputs 0. pix_valid=1 with no frame_start -> no mem_we.
2. Addressing: frame_start, then 4 pairs with pix_valid held high -> mem_addr sequence 2,3,0,1 on consecutive cycles, each with mem_we=1.
3. Header: out_ready=1 -> 54 bytes starting 0x42,0x4D,0x4E,0x00. Byte 18 = 4, byte 22 = 2, byte 28 = 24.
4. Payload order: pair 0 stored as 0x060504030201 -> its bytes are emitted as 01,02,03,04,05,06 at payload positions 12..17.
5. Backpressure: out_ready toggled randomly -> 78 bytes total, no byte duplicated or lost, out_byte stable while stalled. frame_done is a single pulse after byte 78.
6. Abort: HRESETn asserted mid-PAYLOAD -> IDLE next edge, busy=0. A new frame_start then runs a full frame cleanly.
